// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ register-access requesters.
// Optional PREADY watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_write,
  input  logic [NUM_REQ-1:0]            i_slow,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  i_sel,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic                          o_err,
  output logic                          o_busy,
  output logic [ADDR_WIDTH-1:0]         o_m_addr,
  output logic [DATA_WIDTH-1:0]         o_m_data,
  output logic [SEL_WIDTH-1:0]          o_m_sel,
  output logic                          o_m_wait,
  output logic                          o_m_write_trg,
  output logic                          o_m_read_trg,
  input  logic                          i_m_pready,
  input  logic [DATA_WIDTH-1:0]         i_m_prdata
);

  // state | meaning
  // IDLE  | no transfer; sample i_req and grant round-robin
  // ISSUE | one-cycle write/read trigger to the master
  // BUSY  | waiting for PREADY (or watchdog expiry)
  // DONE  | o_ack pulse to granted requester, read data valid
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    BUSY  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        r_ptr, r_grant, pick;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic                    r_write, r_slow, r_err;
  logic                    timeout_hit;
  int                      idx;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts BUSY cycles from 0; expiry is flagged on the last cycle so DONE lands TIMEOUT+1 after ISSUE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               r_cnt <= '0;
    else if (state != BUSY)  r_cnt <= '0;
    else if (!timeout_hit)   r_cnt <= r_cnt + 1'b1;
  end

  assign timeout_hit = (state == BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Search starts just after the last served requester, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    o_m_write_trg = 1'b0;
    o_m_read_trg  = 1'b0;
    o_ack         = '0;
    case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: begin
        o_m_write_trg = r_write;
        o_m_read_trg  = !r_write;
        state_nxt     = BUSY;
      end
      BUSY:  if (i_m_pready || timeout_hit) state_nxt = DONE;
      DONE: begin
        for (int k = 0; k < NUM_REQ; k++) o_ack[k] = (r_grant == PTR_W'(k));
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_write <= 1'b0;
      r_slow  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        r_grant <= pick;
        r_addr  <= i_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= i_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
        r_sel   <= i_sel[pick*SEL_WIDTH +: SEL_WIDTH];
        r_write <= i_write[pick];
        r_slow  <= i_slow[pick];
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
      if (state == BUSY) begin
        if (i_m_pready) begin
          r_rdata <= r_write ? '0 : i_m_prdata;
          r_err   <= 1'b0;
        end else if (timeout_hit) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (state == DONE) r_ptr <= r_grant;
    end
  end

  assign o_busy   = (state != IDLE);
  assign o_m_addr = o_busy ? r_addr  : '0;
  assign o_m_data = o_busy ? r_wdata : '0;
  assign o_m_sel  = o_busy ? r_sel   : '0;
  assign o_m_wait = o_busy & r_slow;
  assign o_rdata  = (state == DONE) ? r_rdata : '0;
  assign o_err    = (state == DONE) & r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small apb_master timing model.
// Define APB_ARB_TIMEOUT_EN to also exercise the PREADY watchdog.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0, write = '0, slow = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N*SW-1:0] sel = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata, m_data, m_prdata;
  logic            err, busy, m_wait, m_wtrg, m_rtrg, m_pready;
  logic [AW-1:0]   m_addr;
  logic [SW-1:0]   m_sel;

  int              total = 0;
  int              bad = 0;
  int unsigned     mcnt;
  logic            pready_en = 1'b1;
  logic [DW-1:0]   mdata = '0;

  always #5 clk = ~clk;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .i_req(req), .i_write(write), .i_slow(slow),
    .i_addr(addr), .i_wdata(wdata), .i_sel(sel), .o_ack(ack), .o_rdata(rdata),
    .o_err(err), .o_busy(busy), .o_m_addr(m_addr), .o_m_data(m_data), .o_m_sel(m_sel),
    .o_m_wait(m_wait), .o_m_write_trg(m_wtrg), .o_m_read_trg(m_rtrg),
    .i_m_pready(m_pready), .i_m_prdata(m_prdata)
  );

  // Master model: PREADY two cycles after the trigger cycle, seven with wait states.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)                mcnt <= 0;
    else if (m_wtrg | m_rtrg) mcnt <= m_wait ? 7 : 2;
    else if (mcnt != 0)       mcnt <= mcnt - 1;
  end
  assign m_pready = pready_en && (mcnt == 1);
  assign m_prdata = mdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic wr, input logic sl, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
    req[k]             = 1'b1;
    write[k]           = wr;
    slow[k]            = sl;
    addr[k*AW +: AW]   = a;
    wdata[k*DW +: DW]  = d;
    sel[k*SW +: SW]    = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_maddr", m_addr, 0);
    rstn = 1'b1;
    tick();
    check("idle_busy", busy, 0);
    check("idle_trg", {m_wtrg, m_rtrg}, 2'b00);

    // Single write from requester 0
    drive(0, 1'b1, 1'b0, 10'h03A, 32'hDEADBEEF, 4'b0001);
    tick();
    check("wr_trg", {m_wtrg, m_rtrg}, 2'b10);
    check("wr_maddr", m_addr, 10'h03A);
    check("wr_mdata", m_data, 32'hDEADBEEF);
    check("wr_msel", m_sel, 4'b0001);
    tick();
    check("wr_trg_c2", {m_wtrg, m_rtrg}, 2'b00);
    check("wr_busy", busy, 1);
    tick();
    check("wr_noack_c3", ack, 0);
    tick();
    check("wr_ack", ack, 4'b0001);
    check("wr_rdata", rdata, 0);
    check("wr_err", err, 0);
    check("wr_maddr_done", m_addr, 10'h03A);
    req[0] = 1'b0;
    tick();
    check("wr_ack_gone", ack, 0);
    check("wr_idle", busy, 0);
    check("wr_maddr_idle", m_addr, 0);

    // Single read from requester 2
    mdata = 32'h12345678;
    drive(2, 1'b0, 1'b0, 10'h1C4, 32'h0, 4'b0100);
    tick();
    check("rd_trg", {m_wtrg, m_rtrg}, 2'b01);
    check("rd_maddr", m_addr, 10'h1C4);
    tick(); tick(); tick();
    check("rd_ack", ack, 4'b0100);
    check("rd_rdata", rdata, 32'h12345678);
    req[2] = 1'b0;
    tick();
    check("rd_rdata_gone", rdata, 0);

    // Slow read from requester 1, address changed mid-transfer
    mdata = 32'hCAFEF00D;
    drive(1, 1'b0, 1'b1, 10'h155, 32'h0, 4'b0010);
    tick();
    check("slow_trg", {m_wtrg, m_rtrg}, 2'b01);
    check("slow_wait", m_wait, 1);
    tick(); tick();
    addr[1*AW +: AW] = 10'h2AA;
    tick(); tick();
    check("slow_maddr_held", m_addr, 10'h155);
    tick(); tick(); tick();
    check("slow_noack_c8", ack, 0);
    tick();
    check("slow_ack_c9", ack, 4'b0010);
    check("slow_rdata", rdata, 32'hCAFEF00D);
    req[1] = 1'b0;
    slow[1] = 1'b0;
    tick();

    // Reset during BUSY, then req0 and req3 pending together
    drive(0, 1'b1, 1'b0, 10'h0F0, 32'h0BADF00D, 4'b0001);
    tick(); tick();
    check("rst_mid_busy_pre", busy, 1);
    rstn = 1'b0;
    drive(3, 1'b1, 1'b0, 10'h3C3, 32'h33333333, 4'b1000);
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_trg", {m_wtrg, m_rtrg}, 2'b00);
    check("rst_mid_maddr", m_addr, 0);
    check("rst_mid_wait", m_wait, 0);
    tick();
    check("rst_mid_ack", ack, 0);
    check("rst_mid_mdata", m_data, 0);
    rstn = 1'b1;
    tick();
    check("post_rst_grant0", m_addr, 10'h0F0);
    check("post_rst_trg", {m_wtrg, m_rtrg}, 2'b10);
    tick(); tick(); tick();
    check("post_rst_ack0", ack, 4'b0001);
    req[0] = 1'b0;
    tick();
    check("post_rst_gap", busy, 0);
    tick();
    check("post_rst_grant3", m_addr, 10'h3C3);
    tick(); tick(); tick();
    check("post_rst_ack3", ack, 4'b1000);
    req[3] = 1'b0;
    tick();

    // All four held: round robin 0,1,2,3,0, five cycles per transfer
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 1'b0, AW'(10'h100 + k * 10'h011), DW'(k), 4'b0001);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("rr_trg", m_wtrg, 1);
      check("rr_maddr", m_addr, 10'h100 + (n % N) * 10'h011);
      tick();
      check("rr_noack_busy", ack, 0);
      tick();
      check("rr_noack_pready", ack, 0);
      tick();
      check("rr_ack", ack, 4'b0001 << (n % N));
      tick();
      check("rr_gap_ack", ack, 0);
      check("rr_gap_busy", busy, 0);
    end
    req = '0;
    tick(); tick();

`ifdef APB_ARB_TIMEOUT_EN
    // PREADY never arrives: ack with error TIMEOUT+1 cycles after ISSUE
    pready_en = 1'b0;
    mdata = 32'hFFFFFFFF;
    drive(0, 1'b0, 1'b0, 10'h011, 32'h0, 4'b0001);
    tick();
    check("to_issue", m_rtrg, 1);
    for (int c = 0; c < TO; c++) begin
      tick();
      check("to_noack", ack, 0);
    end
    tick();
    check("to_ack", ack, 4'b0001);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    req[0] = 1'b0;
    tick();
    check("to_idle", busy, 0);
    check("to_err_gone", err, 0);
    pready_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares one `apb_master` between NUM_REQ independent register-access requesters in the image-filter RX model (DMA config, filter coefficient loader, status poller, debug port). It grants one requester at a time and replays its address, data, select and direction onto the master's trigger interface. It holds those values stable for the whole APB transfer, waits for PREADY, and returns a per-requester acknowledge with captured read data. Only one transaction is outstanding at any time.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_WIDTH, 10: address width
- DATA_WIDTH, 32: data width
- SEL_WIDTH, 4: PSEL width
- TIMEOUT, 16: PREADY watchdog limit in cycles (used only with the configuration macro)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- i_req  in  NUM_REQ  per-requester request; level, held until that requester's o_ack
- i_write  in  NUM_REQ  1 = write, 0 = read
- i_slow  in  NUM_REQ  1 = request wait states (drives o_m_wait)
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- i_sel  in  NUM_REQ*SEL_WIDTH  packed PSEL values
- o_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- o_rdata  out  DATA_WIDTH  read data, valid while o_ack is nonzero
- o_err  out  1  timeout flag, pulses with o_ack
- o_busy  out  1  high when state is not IDLE
- o_m_addr  out  ADDR_WIDTH  to master i_addr
- o_m_data  out  DATA_WIDTH  to master i_data
- o_m_sel  out  SEL_WIDTH  to master i_sel
- o_m_wait  out  1  to master i_wait
- o_m_write_trg  out  1  to master i_write_trg
- o_m_read_trg  out  1  to master i_read_trg
- i_m_pready  in  1  from master o_PREADY
- i_m_prdata  in  DATA_WIDTH  from master o_PRDATA

## Operation
- FSM is one-hot with four states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any i_req is high, grant the first requester found searching from r_ptr+1, wrapping modulo NUM_REQ.
  - Latch that requester's addr, wdata, sel, write and slow bits.
  - Go to ISSUE.
- ISSUE:
  - Assert exactly one trigger for exactly one cycle: o_m_write_trg if the latched write bit is 1, otherwise o_m_read_trg.
  - Go to BUSY.
- BUSY:
  - Triggers are 0.
  - On i_m_pready: if the transfer is a read, capture i_m_prdata; otherwise load 0. Go to DONE.
- DONE:
  - o_ack[grant] = 1 and o_rdata is valid.
  - Set r_ptr to the granted index.
  - Go to IDLE. The next grant cannot occur before the following cycle.
- Master-side outputs (o_m_addr, o_m_data, o_m_sel, o_m_wait):
  - Driven from the latched values in ISSUE, BUSY and DONE.
  - 0 in IDLE.
  - Stable for the whole transfer; live i_addr/i_wdata changes after the grant are ignored.
- i_req is sampled only in IDLE. A request that drops before it is granted is lost without error.
- Requester contract: drop i_req on the clock edge after seeing its o_ack.
- r_ptr resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values: state IDLE, r_ptr NUM_REQ-1; every output and every latched value 0.
- Reset asserted mid-transfer aborts immediately: triggers and o_m_* are 0 and no o_ack is issued.
- Latency with apb_master, request sampled in IDLE at cycle 0:
  - ISSUE at cycle 1, BUSY from cycle 2, PREADY at cycle 3, o_ack at cycle 4.
  - With i_slow=1, the master inserts 5 wait cycles, so o_ack is at cycle 9.
- Throughput: one transfer per 5 cycles minimum, because of the mandatory IDLE gap. The master therefore always returns to its idle state before the next trigger; back-to-back chaining through the master's READY state is never used.
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous full load every requester is served within NUM_REQ transfers.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A BUSY counter starts at 0 on entry to BUSY.
  - If it reaches TIMEOUT with no i_m_pready, go to DONE with o_rdata=0 and o_err=1 for that cycle.
  - PREADY in the same cycle as the limit takes precedence (normal completion, o_err=0).
- Not defined: no counter is built, BUSY waits indefinitely, and o_err is tied to 0.

## Test plan
- Single write: req0, addr 0x3A, data 0xDEADBEEF, sel 4'b0001 → one write_trg pulse at cycle 1; o_m_addr=0x3A held through DONE; o_ack=4'b0001 at cycle 4; o_rdata=0.
- Single read: req2, master returns 0x12345678 → read_trg pulse; o_ack=4'b0100 with o_rdata=0x12345678.
- All four requesters held high → grants in order 0,1,2,3,0; no o_ack overlaps; each transfer 5 cycles apart.
- i_slow=1 on req1 → o_ack at cycle 9; address is not corrupted when i_addr of req1 changes during BUSY.
- Reset pulsed during BUSY → all outputs 0 next cycle; after release, req3 pending together with req0 → req0 granted first.
- With APB_ARB_TIMEOUT_EN and i_m_pready tied 0 → o_err=1, o_ack pulses TIMEOUT+1 cycles after ISSUE, rdata=0; FSM returns to IDLE.
